// File: rtl/mul_pkg.sv
// Shared opcodes, FSM state encoding and default widths for the sequential multiplier.
// Imported by the controller and the partial-product slice.
package mul_pkg;
   localparam int MUL_XLEN = 32;
   localparam int MUL_BPC  = 4;

   localparam logic [1:0] MUL_OP_MUL    = 2'b00;
   localparam logic [1:0] MUL_OP_MULH   = 2'b01;
   localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
   localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } mul_state_e;
endpackage

// File: rtl/mul_pp_slice.sv
// Combinational radix-2^BPC step: running high word plus |a| times one BPC-bit multiplier digit.
// The sum cannot overflow XLEN+BPC bits since both terms are bounded by the operand widths.
module mul_pp_slice
   import mul_pkg::*;
#(
   parameter int XLEN = MUL_XLEN,
   parameter int BPC  = MUL_BPC
) (
   input  logic [XLEN-1:0]     acc_hi_i,
   input  logic [XLEN-1:0]     a_mag_i,
   input  logic [BPC-1:0]      b_dig_i,
   output logic [XLEN+BPC-1:0] sum_o
);
   logic [XLEN+BPC-1:0] a_ext;
   logic [XLEN+BPC-1:0] b_ext;
   logic [XLEN+BPC-1:0] hi_ext;

   assign a_ext  = {{BPC{1'b0}}, a_mag_i};
   assign b_ext  = {{XLEN{1'b0}}, b_dig_i};
   assign hi_ext = {{BPC{1'b0}}, acc_hi_i};
   assign sum_o  = hi_ext + (a_ext * b_ext);
endmodule

// File: rtl/mul_seq_ctrl.sv
// RV32M multiply sequencer: magnitude shift-add over XLEN/BPC cycles, then sign fix; result after XLEN/BPC+1 cycles.
// Result is held in DONE until resp_ready; a new request is only taken in IDLE or on the DONE handshake.
module mul_seq_ctrl
   import mul_pkg::*;
#(
   parameter int XLEN = MUL_XLEN,
   parameter int BPC  = MUL_BPC
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   input  logic [4:0]      tag_in,
   input  logic            kill,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] res,
   output logic [4:0]      tag_out,
   output logic            busy
);
   localparam int STEPS = XLEN / BPC;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

   mul_state_e        state_q, state_d;
   logic [CW-1:0]     count_q, count_d;
   logic [2*XLEN-1:0] p_q, p_d;
   logic [XLEN-1:0]   a_mag_q, a_mag_d;
   logic [1:0]        op_q, op_d;
   logic [4:0]        tag_q, tag_d;
   logic              neg_q, neg_d;
   logic [XLEN-1:0]   res_q, res_d;
   logic              resp_valid_q;
   logic              busy_q;

   logic                accept;
   logic                neg_a;
   logic                neg_b;
   logic [XLEN-1:0]     b_mag;
   logic [XLEN+BPC-1:0] pp_sum;
   logic [2*XLEN-1:0]   p_fix;

   assign req_ready = !RST && !kill &&
                      ((state_q == ST_IDLE) || ((state_q == ST_DONE) && resp_ready));
   assign accept    = req_valid && req_ready;

   // MUL only needs the low word, which is identical for signed and unsigned operands.
   assign neg_a = in_a[XLEN-1] && ((op == MUL_OP_MULH) || (op == MUL_OP_MULHSU));
   assign neg_b = in_b[XLEN-1] && (op == MUL_OP_MULH);
   assign b_mag = neg_b ? -in_b : in_b;
   assign p_fix = neg_q ? -p_q : p_q;

   mul_pp_slice #(.XLEN(XLEN), .BPC(BPC)) u_pp (
      .acc_hi_i (p_q[2*XLEN-1:XLEN]),
      .a_mag_i  (a_mag_q),
      .b_dig_i  (p_q[BPC-1:0]),
      .sum_o    (pp_sum)
   );

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      p_d     = p_q;
      a_mag_d = a_mag_q;
      op_d    = op_q;
      tag_d   = tag_q;
      neg_d   = neg_q;
      res_d   = res_q;

      case (state_q)
         ST_IDLE: ;
         ST_CALC: begin
            // Zero operand short-circuits straight to a zero result on the first CALC cycle.
            if ((count_q == '0) && ((a_mag_q == '0) || (p_q[XLEN-1:0] == '0))) begin
               p_d     = '0;
               res_d   = '0;
               state_d = ST_DONE;
            end else begin
               p_d     = {pp_sum, p_q[XLEN-1:BPC]};
               count_d = count_q + CW'(1);
               if (count_q == CW'(STEPS - 1))
                  state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            p_d     = p_fix;
            res_d   = (op_q == MUL_OP_MUL) ? p_fix[XLEN-1:0] : p_fix[2*XLEN-1:XLEN];
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (resp_ready)
               state_d = ST_IDLE;
         end
      endcase

      if (accept) begin
         state_d = ST_CALC;
         count_d = '0;
         op_d    = op;
         tag_d   = tag_in;
         neg_d   = neg_a ^ neg_b;
         a_mag_d = neg_a ? -in_a : in_a;
         p_d     = {{XLEN{1'b0}}, b_mag};
      end

      if (kill)
         state_d = ST_IDLE;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= ST_IDLE;
         count_q      <= '0;
         p_q          <= '0;
         a_mag_q      <= '0;
         op_q         <= MUL_OP_MUL;
         tag_q        <= '0;
         neg_q        <= 1'b0;
         res_q        <= '0;
         resp_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         p_q          <= p_d;
         a_mag_q      <= a_mag_d;
         op_q         <= op_d;
         tag_q        <= tag_d;
         neg_q        <= neg_d;
         res_q        <= res_d;
         resp_valid_q <= (state_d == ST_DONE);
         busy_q       <= (state_d != ST_IDLE);
      end
   end

   assign resp_valid = resp_valid_q;
   assign busy       = busy_q;
   assign res        = res_q;
   assign tag_out    = tag_q;
endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Sequencing controller for the multi-cycle integer multiplier used by the EX stage of the pipelined RISC-V core. Accepts one RV32M multiply request (MUL/MULH/MULHSU/MULHU) through a valid/ready handshake, runs a radix-2^BPC shift-and-accumulate over the partial-product datapath for XLEN/BPC cycles, applies sign correction, and holds the result until the pipeline takes it. It drives `busy` so hazard logic can stall dependent instructions, and it honours pipeline `kill` (flush).

## Interface
- XLEN, 32, operand/result width
- BPC, 4, multiplier bits consumed per CALC cycle; must divide XLEN
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted on edge where req_valid&&req_ready
- op  in  2  00 MUL (low word), 01 MULH (s×s high), 10 MULHSU (s×u high), 11 MULHU (u×u high)
- in_a  in  XLEN  multiplicand (rs1)
- in_b  in  XLEN  multiplier (rs2)
- tag_in  in  5  destination register tag, echoed on response
- kill  in  1  flush: abandon any operation in progress
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- res  out  XLEN  selected result word
- tag_out  out  5  echoed tag
- busy  out  1  state != IDLE

## Operation
- States: IDLE, CALC, FIX, DONE. Reset → IDLE; res=0, tag_out=0, resp_valid=0, busy=0; req_ready=0 while RST high.
- req_ready = !kill && (IDLE || (DONE && resp_ready)).
- Accept: latch op, tag, sign flags, magnitudes. neg_a = in_a[XLEN-1] && op∈{01,10}; neg_b = in_b[XLEN-1] && op==01; negate = neg_a^neg_b. MUL (00) is treated as unsigned (low word is sign-agnostic). Magnitude of 0x80000000 is 2^31 (fits unsigned).
- Zero shortcut: if either latched operand is zero → DONE directly, product=0.
- Otherwise → CALC, count=0. Product register P[2·XLEN-1:0] = {0, |b|}. Each CALC edge: P[2·XLEN-1:XLEN-BPC... ] ← ({P_hi} + |a|·P[BPC-1:0]) concatenated with P_lo, shifted right by BPC; accumulator width XLEN+BPC, no overflow. count increments; after XLEN/BPC-th CALC edge → FIX.
- FIX: P ← negate ? (−P mod 2^(2·XLEN)) : P → DONE.
- DONE: resp_valid=1; res = op==00 ? P[XLEN-1:0] : P[2·XLEN-1:XLEN]; res and tag_out stable until handshake. On resp_ready: if req_valid&&req_ready accept new request (back-to-back), else → IDLE.
- kill (any state): next edge → IDLE, resp_valid=0, no response ever issued for the killed op; a request presented with kill is not accepted. kill has priority over resp handshake.
- RST mid-operation: immediate return to reset values, no response.

## Timing
- Accept edge T. Normal path: CALC edges T+1..T+XLEN/BPC, FIX edge T+XLEN/BPC+1; resp_valid high from that edge (XLEN=32, BPC=4: resp_valid visible 9 cycles after accept edge).
- Zero shortcut: resp_valid high after edge T+1.
- Throughput: one op per XLEN/BPC+1 cycles with resp_ready held high (back-to-back accept in DONE).
- busy high from edge T until the edge that leaves DONE/IDLE-returns.
- All outputs registered except req_ready (combinational from state, kill, resp_ready).

## Structure
- Shared package mul_pkg: MUL_OP_MUL/MULH/MULHSU/MULHU constants, state encodings, default XLEN.
- Sub-module mul_pp_slice: combinational |a|×BPC-bit partial-product generator plus adder onto the running high word (XLEN+BPC wide); controller instantiates one.
- Controller owns FSM, count (log2(XLEN/BPC) bits), sign flags, P register, handshake.

## Test plan
- MUL 7×6, tag 5 → res=0x0000002A, tag_out=5, resp_valid exactly 9 cycles after accept.
- 0xFFFFFFFF×0xFFFFFFFF: MUL→0x00000001, MULHU→0xFFFFFFFE, MULH→0x00000000, MULHSU→0xFFFFFFFF.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHSU 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF.
- in_a=0, in_b=0x1234 → resp_valid one cycle after accept, res=0.
- kill on 3rd CALC cycle → no resp_valid, busy low next cycle, req_ready high; following MUL 3×5 → 0xF.
- resp_ready low 5 cycles → res/tag_out stable, req_ready low; RST asserted mid-CALC → all outputs at reset values immediately, no response after release.
